// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fetch_fault_e;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic         valid;
        logic [31:0]  pc;
        logic [31:0]  pc4;
        logic [31:0]  instr;
        fetch_fault_e fault;
    } if_id_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC selection and fault classification for the current PC.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int unsigned IMEM_AW = 13
) (
    input  logic [31:0]  pc_i,
    input  logic         stall_i,
    input  logic         halt_i,
    input  logic         redirect_valid_i,
    input  logic [31:0]  redirect_pc_i,
    output logic [31:0]  pc_plus4_o,
    output fetch_fault_e fault_o,
    output logic [31:0]  pc_next_o
);

    always_comb begin
        pc_plus4_o = pc_i + 32'd4;

        // Misalignment outranks range; anything beyond the memory never aliases.
        if (pc_i[1:0] != 2'b00) begin
            fault_o = FAULT_MISALIGN;
        end else if ((pc_i >> (IMEM_AW + 2)) != '0) begin
            fault_o = FAULT_RANGE;
        end else begin
            fault_o = FAULT_NONE;
        end

        if (redirect_valid_i) begin
            pc_next_o = redirect_pc_i;
        end else if (stall_i || halt_i || (fault_o != FAULT_NONE)) begin
            pc_next_o = pc_i;
        end else begin
            pc_next_o = pc_plus4_o;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register, RUN/HALT FSM, fetch counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = 13
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               if_id_valid,
    output logic [31:0]        if_id_pc,
    output logic [31:0]        if_id_pc4,
    output logic [31:0]        if_id_instr,
    output logic [1:0]         if_id_fault,
    output logic [31:0]        fetch_count
);

    logic [31:0]  pc_q, pc_d;
    fetch_state_e state_q, state_d;
    if_id_t       if_id_q, if_id_d;
    logic [31:0]  count_q, count_d;

    logic [31:0]  pc_plus4;
    fetch_fault_e fault;

    fetch_pc_gen #(
        .IMEM_AW (IMEM_AW)
    ) u_pc_gen (
        .pc_i             (pc_q),
        .stall_i          (stall),
        .halt_i           (state_q == ST_HALT),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .pc_plus4_o       (pc_plus4),
        .fault_o          (fault),
        .pc_next_o        (pc_d)
    );

    always_comb begin
        state_d = state_q;
        if_id_d = if_id_q;
        count_d = count_q;

        // Redirect flushes even when decode is stalling.
        if (redirect_valid) begin
            if_id_d.valid = 1'b0;
            state_d       = ST_RUN;
        end else if (!stall) begin
            if (state_q == ST_HALT) begin
                if_id_d.valid = 1'b0;
            end else begin
                if_id_d.valid = 1'b1;
                if_id_d.pc    = pc_q;
                if_id_d.pc4   = pc_plus4;
                if_id_d.fault = fault;
                if_id_d.instr = (fault == FAULT_NONE) ? imem_data : NOP_INSTR;
                count_d       = count_q + 32'd1;
                if (fault != FAULT_NONE) begin
                    state_d = ST_HALT;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= ST_RUN;
            if_id_q <= '{valid: 1'b0, pc: '0, pc4: '0, instr: NOP_INSTR, fault: FAULT_NONE};
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            if_id_q <= if_id_d;
            count_q <= count_d;
        end
    end

    assign imem_addr   = pc_q[IMEM_AW+1:2];
    assign if_id_valid = if_id_q.valid;
    assign if_id_pc    = if_id_q.pc;
    assign if_id_pc4   = if_id_q.pc4;
    assign if_id_instr = if_id_q.instr;
    assign if_id_fault = if_id_q.fault;
    assign fetch_count = count_q;

endmodule
